axis_fifo_reader: RTL
=====================

# axis_fifo_reader

Single-clock AXI4-Stream master that drains the read port of the 14-bit CDC FIFO and emits fixed-length frames of 16-bit beats. It sits on the read-clock side of the FIFO: it drives `rd_en` and consumes the first-word-fall-through `rd_data`/`fifo_empty`. It converts those into a registered `m_axis_*` stream with `tlast` framing and sustains 1 beat/clock at full throughput.

## Interface
- `DATA_W`, 14: FIFO word width.
- `TDATA_W`, 16: stream width; must be ≥ `DATA_W`; the word is zero-extended into the LSBs.
- `FRAME_LEN`, 256: beats per frame, range 1..65535.
- `aclk  in  1`: single clock; it is the FIFO `rd_clk`.
- `aresetn  in  1`: asynchronous, active-low reset.
- `enable  in  1`: start/continue framing; sampled only at frame boundaries.
- `rd_en  out  1`: FIFO pop, combinational.
- `rd_data  in  DATA_W`: FIFO head word; valid whenever `fifo_empty`=0.
- `fifo_empty  in  1`: FIFO empty flag.
- `m_axis_tdata  out  TDATA_W`: stream data.
- `m_axis_tvalid  out  1`: stream valid.
- `m_axis_tready  in  1`: stream ready.
- `m_axis_tlast  out  1`: last beat of frame.
- `m_axis_tuser  out  1`: start-of-frame; present only with `AXIS_TUSER_SOF_EN`.
- `busy  out  1`: high in `STREAM` or `FINISH`.
- `frame_count  out  16`: completed frames; wraps 0xFFFF→0.

## Operation
- **States:**
  - `IDLE`: no pops.
    - `IDLE`→`STREAM` when `enable`=1.
  - `STREAM`: pops allowed.
    - `STREAM`→`FINISH` when `enable`=0 mid-frame (`beat_cnt`≠0 or a beat is pending).
    - `STREAM`→`IDLE` when `enable`=0 at a boundary.
  - `FINISH`: pops continue until the current frame's `tlast` handshake completes, then →`IDLE`. `enable` is ignored in `FINISH`.
- **Load condition:** `load` = state∈{`STREAM`,`FINISH`} & `fifo_empty`=0 & (`m_axis_tvalid`=0 | `m_axis_tready`=1) & ¬(`FINISH` & last beat already loaded).
  - `rd_en` = `load`.
- **On load:**
  - `tdata` ← {zeros, `rd_data`}.
  - `tvalid` ← 1.
  - `tlast` ← (`beat_cnt`==`FRAME_LEN`−1).
  - `beat_cnt` ← (`beat_cnt`==`FRAME_LEN`−1) ? 0 : `beat_cnt`+1. `beat_cnt` is 16 bits.
- **On handshake without load:** `tvalid` ← 0. `tdata`/`tlast` hold their values.
- **AXIS rules:**
  - Once `tvalid`=1, `tdata`/`tlast`/`tuser` stay stable until `tready`=1.
  - `tvalid` never depends combinationally on `tready`.
- **Frame counting:** `frame_count` increments on every handshake with `tlast`=1.
- **Empty FIFO mid-frame:** `tvalid` drops and the frame pauses. `beat_cnt` holds. There is no timeout and no padding.
- **`FRAME_LEN`=1:** every beat carries `tlast`=1 (and `tuser`=1 when enabled).

## Timing
- **Reset values:** `m_axis_tvalid`=0, `m_axis_tdata`=0, `m_axis_tlast`=0, `m_axis_tuser`=0, `busy`=0, `frame_count`=0, `beat_cnt`=0, state=`IDLE`.
- **Reset and the FIFO:** `rd_en`=0 while `aresetn`=0. The FIFO is not reset by this block.
- **Reset mid-frame:** the partial frame is abandoned. After reset, the next word starts a new frame at beat 0.
- **Latency:**
  - `fifo_empty` falling → `tvalid` rising: 1 clock, in `STREAM`.
  - `enable` rising in `IDLE` → first `rd_en`: 1 clock.
- **Throughput:** with `tready`=1 and the FIFO non-empty, one pop and one beat per clock, with no bubbles across frame boundaries.
- **Simultaneous handshake and load:** the register is replaced in the same edge; `tvalid` stays 1.
- **Backpressure:** with `tready`=0, `rd_en`=0 while `tvalid`=1.

## Configuration
- `AXIS_TUSER_SOF_EN` defined:
  - The `m_axis_tuser` port exists.
  - `tuser` ← (`beat_cnt`==0) on load, so it is 1 on the first beat of each frame.
  - It is held stable under backpressure like `tdata`.
- `AXIS_TUSER_SOF_EN` undefined: the port and its register are absent; all other behaviour is identical.

## Test plan
- **Basic frame:** `FRAME_LEN`=4, FIFO preloaded 0x0001..0x0008, `enable`=1, `tready`=1 → 8 consecutive beats `tdata`=0x0001..0x0008, `tlast` on beats 4 and 8, `frame_count`=2, `tuser` on beats 1 and 5.
- **Backpressure:** `tready` toggles 1010… during a frame → no word is lost or duplicated, `tdata` is stable while stalled, and `rd_en` is never high while `tvalid`=1 and `tready`=0.
- **Underflow mid-frame:** `FRAME_LEN`=4, 2 words, wait 10 clocks, 2 more words → `tvalid` is low for the gap and `tlast` is on the 4th word only.
- **Graceful stop:** `enable` drops after beat 2 of 4 → beats 3–4 are still sent, `tlast` is on beat 4, then state=`IDLE`, `busy`=0, and no further pops while the FIFO is non-empty.
- **Reset mid-frame:** `aresetn` low after beat 2 of 4 → outputs take reset values immediately; after release with `enable`=1, the next word is beat 0 (`tuser`=1) and `frame_count`=0.
- **Wrap:** force `frame_count` to 0xFFFF, complete one frame → `frame_count`=0x0000.

Source files
------------

// File: rtl/axis_fifo_reader.sv
// axis_fifo_reader
// Drains the first-word-fall-through read port of the CDC FIFO and emits
// fixed-length AXI4-Stream frames of TDATA_W-bit beats. The output stage is a
// single register slice that reloads in the same edge it is handshaken, so a
// non-empty FIFO with tready=1 streams one beat per clock.
//
// Optional feature: define AXIS_TUSER_SOF_EN to add m_axis_tuser, a
// start-of-frame flag held stable alongside tdata/tlast.
module axis_fifo_reader #(
    parameter int DATA_W    = 14,
    parameter int TDATA_W   = 16,
    parameter int FRAME_LEN = 256
) (
    input  logic               aclk,
    input  logic               aresetn,
    input  logic               enable,
    output logic               rd_en,
    input  logic [DATA_W-1:0]  rd_data,
    input  logic               fifo_empty,
    output logic [TDATA_W-1:0] m_axis_tdata,
    output logic               m_axis_tvalid,
    input  logic               m_axis_tready,
    output logic               m_axis_tlast,
`ifdef AXIS_TUSER_SOF_EN
    output logic               m_axis_tuser,
`endif
    output logic               busy,
    output logic [15:0]        frame_count
);

    localparam logic [15:0] LAST_BEAT = 16'(FRAME_LEN - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STREAM = 2'd1,
        S_FINISH = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_next_state;

    logic [TDATA_W-1:0]  r_tdata;
    logic                r_tvalid;
    logic                r_tlast;
    logic [15:0]         r_beat_cnt;
    logic [15:0]         r_frame_count;

    logic                w_slot_free;
    logic                w_hs;
    logic                w_mid_frame;
    logic                w_beat_last;
    logic                w_pop_ok;
    logic                w_load;
    logic                w_busy;

    // Output register can accept a new word when empty or draining this edge.
    assign w_slot_free = !r_tvalid || m_axis_tready;
    assign w_hs        = r_tvalid && m_axis_tready;
    // A frame is open once its first beat is loaded and until its last is.
    assign w_mid_frame = (r_beat_cnt != 16'd0);
    assign w_beat_last = (r_beat_cnt == LAST_BEAT);
    // aresetn is folded in so the FIFO never sees a pop while held in reset.
    assign w_load      = aresetn && w_pop_ok && !fifo_empty && w_slot_free;

    assign rd_en         = w_load;
    assign m_axis_tdata  = r_tdata;
    assign m_axis_tvalid = r_tvalid;
    assign m_axis_tlast  = r_tlast;
    assign busy          = w_busy;
    assign frame_count   = r_frame_count;

    // State register.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) r_state <= S_IDLE;
        else          r_state <= w_next_state;
    end

    // Next-state: enable only matters at frame boundaries; an open frame, or a
    // loaded tlast beat still waiting for tready, is finished before idling.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (enable) w_next_state = S_STREAM;
            end
            S_STREAM: begin
                if (!enable) begin
                    if (w_mid_frame || (r_tvalid && !m_axis_tready))
                        w_next_state = S_FINISH;
                    else
                        w_next_state = S_IDLE;
                end
            end
            S_FINISH: begin
                if ((w_hs && r_tlast) || (!r_tvalid && !w_mid_frame))
                    w_next_state = S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // Outputs of the FSM: pop permission and busy. In STREAM with enable low
    // at a boundary no new frame is opened; in FINISH only the open frame's
    // remaining beats may be popped (beat_cnt==0 there means tlast is loaded).
    always_comb begin
        w_pop_ok = 1'b0;
        w_busy   = 1'b0;
        case (r_state)
            S_STREAM: begin
                w_pop_ok = enable || w_mid_frame;
                w_busy   = 1'b1;
            end
            S_FINISH: begin
                w_pop_ok = w_mid_frame;
                w_busy   = 1'b1;
            end
            default: begin
                w_pop_ok = 1'b0;
                w_busy   = 1'b0;
            end
        endcase
    end

    // Valid flag: set on load, cleared by a handshake with no replacement.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn)  r_tvalid <= 1'b0;
        else if (w_load) r_tvalid <= 1'b1;
        else if (w_hs)   r_tvalid <= 1'b0;
    end

    // Payload: only written on load, so it holds steady under backpressure.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_tdata <= '0;
            r_tlast <= 1'b0;
        end else if (w_load) begin
            r_tdata <= TDATA_W'(rd_data);
            r_tlast <= w_beat_last;
        end
    end

`ifdef AXIS_TUSER_SOF_EN
    logic r_tuser;

    // Start-of-frame flag, loaded with the payload.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn)    r_tuser <= 1'b0;
        else if (w_load) r_tuser <= !w_mid_frame;
    end

    assign m_axis_tuser = r_tuser;
`endif

    // Beat position within the frame; advances per popped word, holds on gaps.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_beat_cnt <= 16'd0;
        end else if (w_load) begin
            if (w_beat_last) r_beat_cnt <= 16'd0;
            else             r_beat_cnt <= r_beat_cnt + 16'd1;
        end
    end

    // Completed frames, counted at the tlast handshake; wraps naturally.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn)              r_frame_count <= 16'd0;
        else if (w_hs && r_tlast)  r_frame_count <= r_frame_count + 16'd1;
    end

endmodule
